chip_axil_arbiter: RTL and testbench

- Two-requester AXI4-Lite arbiter that shares the single S00_AXI register port of chip_fsm_controller (four 32-bit registers at offsets 0x0-0xC).
- Requester 0 is the PS/VIP master path. Requester 1 is the on-chip test sequencer.
- Exactly one transaction (write or read) is in flight at a time. Grants are round-robin between requesters.

---
 rtl/chip_axil_arbiter_if.sv | 42 ++++
 rtl/chip_axil_arbiter.sv | 155 +++++++++++++++
 tb/tb_chip_axil_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip_axil_arbiter_if.sv
// AXI4-Lite bundle carrying N independent lanes. Lane i of every field sits
// at bits [i*W +: W]. The arbiter is a slave on the two-lane requester side
// and a master on the single-lane slave side.
interface chip_axil_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int N      = 1
);
  logic [N*ADDR_W-1:0]     awaddr;
  logic [N-1:0]            awvalid;
  logic [N-1:0]            awready;
  logic [N*DATA_W-1:0]     wdata;
  logic [N*DATA_W/8-1:0]   wstrb;
  logic [N-1:0]            wvalid;
  logic [N-1:0]            wready;
  logic [2*N-1:0]          bresp;
  logic [N-1:0]            bvalid;
  logic [N-1:0]            bready;
  logic [N*ADDR_W-1:0]     araddr;
  logic [N-1:0]            arvalid;
  logic [N-1:0]            arready;
  logic [N*DATA_W-1:0]     rdata;
  logic [2*N-1:0]          rresp;
  logic [N-1:0]            rvalid;
  logic [N-1:0]            rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/chip_axil_arbiter.sv
// Two-requester AXI4-Lite arbiter in front of a single register slave.
// One transaction in flight at a time, round-robin on conflicts, writes
// preferred over reads within a requester. Only ready/valid and the
// granted lane's payload are forwarded combinationally.
module chip_axil_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  chip_axil_arbiter_if.slave   s,
  chip_axil_arbiter_if.master  m,
  output logic                 grant,
  output logic                 busy
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t     state, state_nxt;
  logic       rr, rr_nxt;
  logic       grant_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;
  logic       sel;
  logic [1:0] wr_req, rd_req, req;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign wr_req = s.awvalid & s.wvalid;
  assign rd_req = s.arvalid;
  assign req    = wr_req | rd_req;
  assign busy   = (state != IDLE);

  assign aw_hs = m.awvalid[0] & m.awready[0];
  assign w_hs  = m.wvalid[0]  & m.wready[0];
  assign b_hs  = m.bvalid[0]  & m.bready[0];
  assign ar_hs = m.arvalid[0] & m.arready[0];
  assign r_hs  = m.rvalid[0]  & m.rready[0];

  // Control registers: state, grant, round-robin pointer and write-phase flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      rr      <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr      <= rr_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Arbitration and transaction sequencing.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_nxt      = rr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    sel         = rr;
    case (state)
      IDLE: begin
        if (|req) begin
          // On a conflict rr decides; otherwise the lone requester wins.
          sel       = (&req) ? rr : req[1];
          grant_nxt = sel;
          state_nxt = wr_req[sel] ? WADDR : RADDR;
        end
      end
      WADDR: begin
        // AW and W may finish in either order; remember each one so it is
        // never presented to the slave twice.
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          state_nxt   = WRESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end
      WRESP: begin
        if (b_hs) begin
          state_nxt = IDLE;
          rr_nxt    = ~grant;
        end
      end
      RADDR: begin
        if (ar_hs) state_nxt = RDATA;
      end
      RDATA: begin
        if (r_hs) begin
          state_nxt = IDLE;
          rr_nxt    = ~grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus forwarding: granted lane's payload and handshakes, everything else zero.
  always_comb begin
    m.awaddr  = grant ? s.awaddr[2*ADDR_W-1:ADDR_W] : s.awaddr[ADDR_W-1:0];
    m.wdata   = grant ? s.wdata[2*DATA_W-1:DATA_W]  : s.wdata[DATA_W-1:0];
    m.wstrb   = grant ? s.wstrb[2*STRB_W-1:STRB_W]  : s.wstrb[STRB_W-1:0];
    m.araddr  = grant ? s.araddr[2*ADDR_W-1:ADDR_W] : s.araddr[ADDR_W-1:0];
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    s.awready = '0;
    s.wready  = '0;
    s.bvalid  = '0;
    s.bresp   = '0;
    s.arready = '0;
    s.rvalid  = '0;
    s.rdata   = '0;
    s.rresp   = '0;
    case (state)
      WADDR: begin
        m.awvalid[0]     = s.awvalid[grant] & ~aw_done;
        m.wvalid[0]      = s.wvalid[grant] & ~w_done;
        s.awready[grant] = m.awready[0] & ~aw_done;
        s.wready[grant]  = m.wready[0] & ~w_done;
      end
      WRESP: begin
        m.bready[0]     = s.bready[grant];
        s.bvalid[grant] = m.bvalid[0];
        if (grant) s.bresp[3:2] = m.bresp;
        else       s.bresp[1:0] = m.bresp;
      end
      RADDR: begin
        m.arvalid[0]     = s.arvalid[grant];
        s.arready[grant] = m.arready[0];
      end
      RDATA: begin
        m.rready[0]     = s.rready[grant];
        s.rvalid[grant] = m.rvalid[0];
        if (grant) begin
          s.rdata[2*DATA_W-1:DATA_W] = m.rdata;
          s.rresp[3:2]               = m.rresp;
        end else begin
          s.rdata[DATA_W-1:0] = m.rdata;
          s.rresp[1:0]        = m.rresp;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_chip_axil_arbiter.sv
// Directed bench for chip_axil_arbiter: two requester drivers, a four-register
// AXI4-Lite slave model with adjustable AW/W ready delays and B stall, and a
// grant log recorded at the start of every transaction.
module tb_chip_axil_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic grant, busy;

  always #5 clock = ~clock;

  chip_axil_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N(2)) s_if ();
  chip_axil_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N(1)) m_if ();

  chip_axil_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .s     (s_if),
    .m     (m_if),
    .grant (grant),
    .busy  (busy)
  );

  // Requester-side stimulus
  logic [7:0]  rq_awaddr = '0;
  logic [1:0]  rq_awvalid = '0;
  logic [63:0] rq_wdata = '0;
  logic [7:0]  rq_wstrb = '0;
  logic [1:0]  rq_wvalid = '0;
  logic [1:0]  rq_bready = '0;
  logic [7:0]  rq_araddr = '0;
  logic [1:0]  rq_arvalid = '0;
  logic [1:0]  rq_rready = '0;

  assign s_if.awaddr  = rq_awaddr;
  assign s_if.awvalid = rq_awvalid;
  assign s_if.wdata   = rq_wdata;
  assign s_if.wstrb   = rq_wstrb;
  assign s_if.wvalid  = rq_wvalid;
  assign s_if.bready  = rq_bready;
  assign s_if.araddr  = rq_araddr;
  assign s_if.arvalid = rq_arvalid;
  assign s_if.rready  = rq_rready;

  int checks = 0;
  int errors = 0;

  // Slave model
  logic [31:0] regs [4];
  logic        aw_have = 1'b0, w_have = 1'b0;
  logic [3:0]  aw_addr_l = '0;
  logic [31:0] w_data_l = '0;
  logic [3:0]  w_strb_l = '0;
  int aw_wait = 0, w_wait = 0;
  int aw_delay = 0, w_delay = 0;
  logic b_stall = 1'b0;
  int cyc = 0, aw_cnt = 0, w_cnt = 0, wr_cnt = 0, aw_cyc = 0, w_cyc = 0;

  assign m_if.awready = m_if.awvalid & (aw_wait >= aw_delay);
  assign m_if.wready  = m_if.wvalid & (w_wait >= w_delay);
  assign m_if.arready = m_if.arvalid & ~m_if.rvalid;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      aw_have      <= 1'b0;
      w_have       <= 1'b0;
      aw_wait      <= 0;
      w_wait       <= 0;
      m_if.bvalid  <= '0;
      m_if.bresp   <= '0;
      m_if.rvalid  <= '0;
      m_if.rdata   <= '0;
      m_if.rresp   <= '0;
      for (int k = 0; k < 4; k++) regs[k] <= '0;
    end else begin
      if (aw_have && w_have && !m_if.bvalid[0] && !b_stall) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_l[b]) regs[aw_addr_l[3:2]][b*8 +: 8] <= w_data_l[b*8 +: 8];
        m_if.bvalid <= 1'b1;
        m_if.bresp  <= 2'b00;
        aw_have     <= 1'b0;
        w_have      <= 1'b0;
        wr_cnt      <= wr_cnt + 1;
      end else if (m_if.bvalid[0] && m_if.bready[0]) begin
        m_if.bvalid <= 1'b0;
      end
      if (m_if.awvalid[0] && m_if.awready[0]) begin
        aw_have   <= 1'b1;
        aw_addr_l <= m_if.awaddr;
        aw_cnt    <= aw_cnt + 1;
        aw_cyc    <= cyc;
        aw_wait   <= 0;
      end else if (m_if.awvalid[0]) begin
        aw_wait <= aw_wait + 1;
      end
      if (m_if.wvalid[0] && m_if.wready[0]) begin
        w_have   <= 1'b1;
        w_data_l <= m_if.wdata;
        w_strb_l <= m_if.wstrb;
        w_cnt    <= w_cnt + 1;
        w_cyc    <= cyc;
        w_wait   <= 0;
      end else if (m_if.wvalid[0]) begin
        w_wait <= w_wait + 1;
      end
      if (m_if.arvalid[0] && m_if.arready[0]) begin
        m_if.rvalid <= 1'b1;
        m_if.rdata  <= regs[m_if.araddr[3:2]];
        m_if.rresp  <= 2'b00;
      end else if (m_if.rvalid[0] && m_if.rready[0]) begin
        m_if.rvalid <= 1'b0;
      end
    end
  end

  // Grant log: one entry per transaction, taken on the first busy cycle
  int   glog [64];
  int   gcnt = 0;
  logic busy_q = 1'b0;

  always @(negedge clock) begin
    busy_q <= busy;
    if (busy && !busy_q && gcnt < 64) begin
      glog[gcnt] <= int'(grant);
      gcnt       <= gcnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset = 1'b1;
    rq_awaddr = '0; rq_awvalid = '0; rq_wdata = '0; rq_wstrb = '0; rq_wvalid = '0;
    rq_bready = '0; rq_araddr = '0; rq_arvalid = '0; rq_rready = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic req_write(input int i, input logic [3:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
    bit aw_pend, w_pend, aw_hit, w_hit, b_hit;
    int n;
    rq_awaddr[i*4 +: 4]  = addr;
    rq_wdata[i*32 +: 32] = data;
    rq_wstrb[i*4 +: 4]   = 4'hF;
    rq_awvalid[i] = 1'b1;
    rq_wvalid[i]  = 1'b1;
    rq_bready[i]  = 1'b1;
    aw_pend = 1; w_pend = 1; b_hit = 0; n = 0; resp = 2'b11;
    while ((aw_pend || w_pend) && n < 200) begin
      @(negedge clock);
      aw_hit = aw_pend && s_if.awready[i];
      w_hit  = w_pend && s_if.wready[i];
      @(posedge clock); #1;
      if (aw_hit) begin rq_awvalid[i] = 1'b0; aw_pend = 0; end
      if (w_hit)  begin rq_wvalid[i] = 1'b0;  w_pend = 0;  end
      n++;
    end
    while (!b_hit && n < 200) begin
      @(negedge clock);
      b_hit = s_if.bvalid[i];
      if (b_hit) resp = s_if.bresp[i*2 +: 2];
      @(posedge clock); #1;
      n++;
    end
    rq_awvalid[i] = 1'b0; rq_wvalid[i] = 1'b0; rq_bready[i] = 1'b0;
    if (!b_hit) begin
      checks++; errors++;
      $display("FAIL write_timeout req%0d addr 0x%0h: got no B response, required within 200 cycles", i, addr);
    end
  endtask

  task automatic req_read(input int i, input logic [3:0] addr, input int rdly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit ar_hit, r_hit;
    int n, seen;
    rq_araddr[i*4 +: 4] = addr;
    rq_arvalid[i] = 1'b1;
    rq_rready[i]  = 1'b0;
    ar_hit = 0; r_hit = 0; n = 0; seen = 0; data = 'x; resp = 2'b11;
    while (!ar_hit && n < 200) begin
      @(negedge clock);
      ar_hit = s_if.arready[i];
      @(posedge clock); #1;
      n++;
    end
    rq_arvalid[i] = 1'b0;
    while (ar_hit && !r_hit && n < 200) begin
      @(negedge clock);
      if (s_if.rvalid[i]) begin
        if (rq_rready[i]) begin
          r_hit = 1;
          data  = s_if.rdata[i*32 +: 32];
          resp  = s_if.rresp[i*2 +: 2];
        end else begin
          seen++;
        end
      end
      @(posedge clock); #1;
      if (!r_hit && seen >= rdly) rq_rready[i] = 1'b1;
      n++;
    end
    rq_rready[i] = 1'b0;
    if (!r_hit) begin
      checks++; errors++;
      $display("FAIL read_timeout req%0d addr 0x%0h: got no R response, required within 200 cycles", i, addr);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || grant !== 1'b0) begin
      errors++; $display("FAIL reset_busy_grant: got busy=%b grant=%b, required 0 0", busy, grant);
    end
    checks++;
    if ({m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_master_ctl: got %b, required 00000",
                         {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready});
    end
    checks++;
    if ({s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid} !== 10'b0) begin
      errors++; $display("FAIL reset_slave_ctl: got %b, required 0",
                         {s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single_requester();
    logic [1:0]  resp;
    logic [31:0] data;
    fork
      req_write(0, 4'h0, 32'h1, resp);
      begin
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL arb_cycle_busy: got %b, required 0", busy);
        end
        @(negedge clock);
        checks++;
        if ({busy, m_if.awvalid} !== 2'b11) begin
          errors++; $display("FAIL waddr_busy_awvalid: got %b, required 11", {busy, m_if.awvalid});
        end
      end
    join
    checks++;
    if (busy !== 1'b0 || resp !== 2'b00) begin
      errors++; $display("FAIL first_write_done: got busy=%b bresp=%b, required 0 00", busy, resp);
    end
    for (int k = 1; k < 4; k++) begin
      req_write(0, 4'(k * 4), 32'(k + 1), resp);
      checks++;
      if (resp !== 2'b00) begin
        errors++; $display("FAIL single_bresp k=%0d: got %b, required 00", k, resp);
      end
    end
    for (int k = 0; k < 4; k++) begin
      req_read(0, 4'(k * 4), 0, data, resp);
      checks++;
      if (data !== 32'(k + 1) || resp !== 2'b00 || grant !== 1'b0) begin
        errors++; $display("FAIL single_read addr=0x%0h: got data=0x%0h resp=%b grant=%b, required 0x%0h 00 0",
                           k * 4, data, resp, grant, k + 1);
      end
    end
  endtask

  task automatic test_conflict_writes();
    logic [1:0]  r0, r1;
    logic [31:0] d0, d1;
    int g0;
    apply_reset();
    g0 = gcnt;
    fork
      req_write(0, 4'h0, 32'hAAAA0000, r0);
      req_write(1, 4'h4, 32'h5555FFFF, r1);
    join
    checks++;
    if (gcnt - g0 !== 2 || glog[g0] !== 0 || glog[g0+1] !== 1) begin
      errors++; $display("FAIL conflict_write_order: got n=%0d first=%0d second=%0d, required 2 0 1",
                         gcnt - g0, glog[g0], glog[g0+1]);
    end
    checks++;
    if (r0 !== 2'b00 || r1 !== 2'b00) begin
      errors++; $display("FAIL conflict_bresp: got %b %b, required 00 00", r0, r1);
    end
    fork
      req_read(0, 4'h0, 0, d0, r0);
      req_read(1, 4'h4, 0, d1, r1);
    join
    checks++;
    if (d0 !== 32'hAAAA0000 || d1 !== 32'h5555FFFF) begin
      errors++; $display("FAIL conflict_readback: got 0x%0h 0x%0h, required 0xaaaa0000 0x5555ffff", d0, d1);
    end
    checks++;
    if (glog[g0+2] !== 0 || glog[g0+3] !== 1) begin
      errors++; $display("FAIL conflict_rr_after: got %0d %0d, required 0 1", glog[g0+2], glog[g0+3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ra, rb, rw;
    logic [31:0] da, db;
    int g0;
    req_write(1, 4'h8, 32'hCAFE0008, rw);
    g0 = gcnt;
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          req_read(0, 4'h8, 0, da, ra);
          checks++;
          if (da !== 32'hCAFE0008 || ra !== 2'b00) begin
            errors++; $display("FAIL b2b_read_r0 k=%0d: got 0x%0h %b, required 0xcafe0008 00", k, da, ra);
          end
        end
      end
      begin
        for (int j = 0; j < 2; j++) begin
          req_read(1, 4'h8, 0, db, rb);
          checks++;
          if (db !== 32'hCAFE0008 || rb !== 2'b00) begin
            errors++; $display("FAIL b2b_read_r1 k=%0d: got 0x%0h %b, required 0xcafe0008 00", j, db, rb);
          end
        end
      end
    join
    checks++;
    if (gcnt - g0 !== 4 || glog[g0] !== 0 || glog[g0+1] !== 1 || glog[g0+2] !== 0 || glog[g0+3] !== 1) begin
      errors++; $display("FAIL b2b_alternation: got n=%0d %0d%0d%0d%0d, required 4 0101",
                         gcnt - g0, glog[g0], glog[g0+1], glog[g0+2], glog[g0+3]);
    end
  endtask

  task automatic test_aw_w_order();
    logic [1:0]  resp;
    logic [31:0] data;
    int a0, w0, c0;
    aw_delay = 3; w_delay = 0;
    a0 = aw_cnt; w0 = w_cnt; c0 = wr_cnt;
    req_write(0, 4'hC, 32'h12345678, resp);
    checks++;
    if (aw_cnt - a0 !== 1 || w_cnt - w0 !== 1 || wr_cnt - c0 !== 1) begin
      errors++; $display("FAIL w_first_counts: got aw=%0d w=%0d wr=%0d, required 1 1 1",
                         aw_cnt - a0, w_cnt - w0, wr_cnt - c0);
    end
    checks++;
    if (aw_cyc - w_cyc !== 3) begin
      errors++; $display("FAIL w_first_gap: got %0d cycles, required 3", aw_cyc - w_cyc);
    end
    aw_delay = 0;
    req_read(0, 4'hC, 0, data, resp);
    checks++;
    if (data !== 32'h12345678) begin
      errors++; $display("FAIL w_first_readback: got 0x%0h, required 0x12345678", data);
    end
    a0 = aw_cnt; w0 = w_cnt; c0 = wr_cnt;
    req_write(0, 4'hC, 32'h87654321, resp);
    checks++;
    if (aw_cnt - a0 !== 1 || w_cnt - w0 !== 1 || wr_cnt - c0 !== 1 || aw_cyc !== w_cyc) begin
      errors++; $display("FAIL same_cycle_counts: got aw=%0d w=%0d wr=%0d gap=%0d, required 1 1 1 0",
                         aw_cnt - a0, w_cnt - w0, wr_cnt - c0, aw_cyc - w_cyc);
    end
    req_read(0, 4'hC, 0, data, resp);
    checks++;
    if (data !== 32'h87654321) begin
      errors++; $display("FAIL same_cycle_readback: got 0x%0h, required 0x87654321", data);
    end
  endtask

  task automatic test_rready_stall();
    logic [1:0]  r0, r1;
    logic [31:0] d0, d1;
    int g0;
    g0 = gcnt;
    fork
      req_read(1, 4'hC, 5, d1, r1);
      begin
        repeat (2) @(posedge clock);
        #1;
        req_read(0, 4'h8, 0, d0, r0);
      end
      begin
        repeat (3) @(posedge clock);
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          checks++;
          if ({m_if.rvalid, m_if.rready, busy, grant, s_if.arready[0]} !== 5'b10110 ||
              s_if.rdata[31:0] !== 32'h0) begin
            errors++; $display("FAIL rdata_hold k=%0d: got rvalid,rready,busy,grant,arready0=%b lane0=0x%0h, required 10110 0x0",
                               k, {m_if.rvalid, m_if.rready, busy, grant, s_if.arready[0]}, s_if.rdata[31:0]);
          end
        end
      end
    join
    checks++;
    if (d1 !== 32'h87654321 || d0 !== 32'hCAFE0008 || r0 !== 2'b00 || r1 !== 2'b00) begin
      errors++; $display("FAIL stall_data: got r1=0x%0h r0=0x%0h, required 0x87654321 0xcafe0008", d1, d0);
    end
    checks++;
    if (gcnt - g0 !== 2 || glog[g0] !== 1 || glog[g0+1] !== 0) begin
      errors++; $display("FAIL stall_order: got n=%0d %0d%0d, required 2 10", gcnt - g0, glog[g0], glog[g0+1]);
    end
  endtask

  task automatic test_reset_wresp();
    logic [1:0]  r0, r1;
    logic [31:0] d0, d1;
    bit found;
    int n, g0;
    b_stall = 1'b1;
    rq_awaddr[7:4]   = 4'h4;
    rq_wdata[63:32]  = 32'hDEADBEEF;
    rq_wstrb[7:4]    = 4'hF;
    rq_awvalid[1] = 1'b1; rq_wvalid[1] = 1'b1; rq_bready[1] = 1'b1;
    found = 0; n = 0;
    while (!found && n < 20) begin
      @(negedge clock);
      found = busy && m_if.bready[0];
      n++;
    end
    checks++;
    if (!found || grant !== 1'b1) begin
      errors++; $display("FAIL wresp_reached: got found=%0d grant=%b, required 1 1", found, grant);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    rq_awvalid = '0; rq_wvalid = '0; rq_bready = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    b_stall = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || grant !== 1'b0 ||
        {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready} !== 5'b0 ||
        {s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid} !== 10'b0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%b grant=%b mctl=%b sctl=%b, required all 0", busy, grant,
                         {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready},
                         {s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid});
    end
    @(posedge clock); #1;
    g0 = gcnt;
    fork
      req_read(0, 4'h0, 0, d0, r0);
      req_read(1, 4'h4, 0, d1, r1);
    join
    checks++;
    if (gcnt - g0 !== 2 || glog[g0] !== 0 || glog[g0+1] !== 1) begin
      errors++; $display("FAIL midreset_rr: got n=%0d %0d%0d, required 2 01", gcnt - g0, glog[g0], glog[g0+1]);
    end
    checks++;
    if (d0 !== 32'h0 || d1 !== 32'h0) begin
      errors++; $display("FAIL midreset_regs: got 0x%0h 0x%0h, required 0x0 0x0", d0, d1);
    end
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_conflict_writes();
    test_back_to_back();
    test_aw_w_order();
    test_rready_stall();
    test_reset_wresp();
    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
